// File: rtl/rf_scan_pkg.sv
// Shared types and constants for the register-file scan reader.
package rf_scan_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  // The self-check pattern: register k is expected to hold the value k.
  function automatic logic [RF_DATA_W-1:0] expected_word(input logic [RF_ADDR_W-1:0] addr);
    return {{(RF_DATA_W - RF_ADDR_W){1'b0}}, addr};
  endfunction

endpackage

// File: rtl/rf_scan_acc.sv
// Checksum and mismatch accumulator for words accepted by the consumer.
module rf_scan_acc
  import rf_scan_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic              check_en,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [DATA_W-1:0] word_data,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   err_cnt
);

  logic mismatch;

  assign mismatch = check_en &&
                    (word_data != DATA_W'(expected_word(RF_ADDR_W'(word_addr))));

  // Clear on an accepted start, otherwise accumulate each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
      err_cnt  <= '0;
    end else if (clear) begin
      checksum <= '0;
      err_cnt  <= '0;
    end else if (accept) begin
      // NOTE: non-blocking so every register samples pre-edge values; blocking here would create order-dependent races between always blocks.
      checksum <= checksum + word_data;
      if (mismatch) begin
        err_cnt <= err_cnt + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/rf_scan_reader.sv
// Walks an address range through one rf read port and streams each word
// out on a valid/ready interface, optionally self-checking against reg[k]=k.
module rf_scan_reader
  import rf_scan_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  input  logic              check_en,
  output logic [ADDR_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W:0]   err_cnt
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] last_q;
  logic              chk_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              start_ok;
  logic              handshake;
  logic              at_last;

  // Abort beats both a start request and a handshake in the same cycle.
  assign start_ok  = (state_q == IDLE) && start && !abort;
  assign handshake = (state_q == SEND) && out_ready && !abort;
  assign at_last   = (addr_q == last_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_ok) state_d = (first_addr > last_addr) ? DONE : READ;
      READ: state_d = SEND;
      SEND: if (handshake) state_d = at_last ? DONE : READ;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Range latch, address walker and output word capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every datapath register is reset so all outputs read 0 right after rst.
    if (rst) begin
      addr_q     <= '0;
      last_q     <= '0;
      chk_q      <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      if (start_ok) begin
        addr_q <= first_addr;
        last_q <= last_addr;
        chk_q  <= check_en;
      end
      if (state_q == READ) begin
        out_addr_q <= addr_q;
        out_data_q <= rf_rd;
      end
      // Stop at last_addr so the address never wraps past the top register.
      if (handshake && !at_last) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  rf_scan_acc #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_ok),
    .accept   (handshake),
    .check_en (chk_q),
    .word_addr(out_addr_q),
    .word_data(out_data_q),
    .checksum (checksum),
    .err_cnt  (err_cnt)
  );

  assign rf_a      = addr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == SEND);
  assign busy      = (state_q == READ) || (state_q == SEND);
  assign done      = (state_q == DONE);

endmodule

// File: doc/rf_scan_reader.md
Name: rf_scan_reader

Overview:
- Sequential reader for the CPU register file (rf). It walks a programmed address range through one rf read port (a1/rd1) and streams each word out on a valid/ready interface.
- Optionally self-checks each word against the pattern reg[k] = k and accumulates a checksum and a mismatch count.
- Sits beside rf as the read-side counterpart of the write sequences the bench applies through a3/wd/rfwr. Used for post-program register dumps and regression self-checks.

Parameters:
- ADDR_W, 5, rf address width (32 registers).
- DATA_W, 32, rf data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; ignored unless idle.
- abort  input  1  terminates a scan in progress.
- first_addr  input  ADDR_W  first register to read; latched on accepted start.
- last_addr  input  ADDR_W  last register to read, inclusive; latched on accepted start.
- check_en  input  1  enables pattern compare; latched on accepted start.
- rf_a  output  ADDR_W  drives rf a1.
- rf_rd  input  DATA_W  rf rd1, combinational read data.
- out_valid  output  1  out_addr/out_data hold a valid word.
- out_ready  input  1  consumer accepts the word.
- out_addr  output  ADDR_W  address of the streamed word.
- out_data  output  DATA_W  streamed register contents.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse on normal scan completion.
- checksum  output  DATA_W  sum mod 2^DATA_W of accepted words.
- err_cnt  output  ADDR_W+1  count of accepted words with data != zero-extended address.

Behaviour:
- Reset: async on rst high. State goes to IDLE. All outputs and internal registers go to 0, including rf_a, out_*, busy, done, checksum and err_cnt.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE, start=1:
  - latch first_addr, last_addr, check_en;
  - clear checksum and err_cnt;
  - addr <= first_addr;
  - if first_addr > last_addr go to DONE (empty scan), else go to READ.
- READ:
  - rf_a = addr;
  - capture out_data <= rf_rd and out_addr <= addr at the clock edge;
  - go to SEND.
- SEND:
  - out_valid = 1; out_addr and out_data held stable while out_ready = 0.
  - On handshake (out_valid and out_ready):
    - checksum += out_data;
    - if check_en and out_data != {0, out_addr}, err_cnt += 1;
    - if addr == last_addr go to DONE, else addr <= addr + 1 and go to READ.
- DONE:
  - done = 1 for exactly one cycle; go to IDLE.
  - checksum and err_cnt hold until the next accepted start.
- rf_a is registered and equals addr in every state. It is 0 after reset.
- busy = 1 in READ and SEND, 0 in IDLE and DONE.
- out_valid = 1 only in SEND.
- Throughput: one word per 2 cycles with out_ready held at 1.
- Latency: N words with out_ready = 1 and start accepted at edge t0:
  - word k handshakes at edge t0 + 2k + 2, for k = 0..N-1;
  - done is high in the cycle after the last handshake.
- Wrap-around: last_addr = 31 ends the scan without incrementing past 31. addr never wraps.
- abort, any non-IDLE state: go to IDLE next edge. out_valid drops, no done pulse, checksum and err_cnt keep their partial values.
  - abort has priority over a handshake in the same cycle; that word is not counted.
- start in any state other than IDLE is ignored. start and abort together in IDLE: abort wins, start is ignored.
- Reg 0 reads as 0 and is expected to be 0.

Decomposition:
- Package rf_scan_pkg holds:
  - state enum {IDLE, READ, SEND, DONE};
  - constants RF_ADDR_W = 5 and RF_DATA_W = 32;
  - function expected_word(addr), which zero-extends addr.
- Optional sub-module: rf_scan_acc, holding the checksum/err_cnt accumulator with clear and handshake-enable inputs. Everything else stays flat.

Test Plan:
- Write reg k = k for k = 1..9 via rfwr; start with first = 0, last = 9, check_en = 1, out_ready = 1 -> 10 words, addr/data 0..9 in order; checksum = 45; err_cnt = 0; done high at t0 + 21; busy low after.
- Same data, reg 3 = 0x55 -> err_cnt = 1, checksum = 127. Repeat with check_en = 0 -> err_cnt = 0, checksum = 127.
- Backpressure: first = 4, last = 6, out_ready low for 5 cycles on the first word -> out_addr = 4, out_data = 4 stable throughout; then words 5 and 6; checksum = 15.
- Empty and boundary ranges:
  - first = 5, last = 2 -> no out_valid, done at t0 + 1, checksum = 0;
  - first = last = 31 with reg 31 = 0xDEADBEEF -> single word, checksum = 0xDEADBEEF, err_cnt = 1.
- Abort and reset:
  - abort during the third SEND of a 0..9 scan -> idle next cycle, no done, checksum = 1 (0 + 1);
  - rst asserted mid-scan -> all outputs 0 immediately; a new start then runs cleanly.
- start pulsed while busy -> ignored, the original range completes unchanged.
